qu_decoder: RTL and testbench
=============================

Name: qu_decoder

Overview:
- Registered RV32I instruction decode stage between fetch and issue.
- Splits each instruction word into fields, generates a sign-extended immediate and classifies the format.
- Flags illegal encodings.
- valid/ready on both sides, two-entry skid buffer (full throughput under backpressure), synchronous flush for branch redirect.

Parameters:
- XLEN, 32, immediate/output data width (>=32; immediates sign-extended to XLEN)
- ADDR_WIDTH, 32, PC width carried alongside each instruction

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all buffered instructions this cycle
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  decoder accepts when in_valid&in_ready
- in_instr  in  32  instruction word
- in_pc  in  ADDR_WIDTH  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  issue consumes when out_valid&out_ready
- out_pc  out  ADDR_WIDTH  PC of entry
- out_opcode  out  7  opcode field
- out_funct3  out  3  funct3 field
- out_funct7  out  7  funct7 field
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses
- out_imm  out  XLEN  sign-extended immediate (0 for R-type)
- out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J
- out_illegal  out  1  encoding illegal; other fields undefined except out_pc
- out_is_mul  out  1  M-extension op (only with QU_RV32M_EN, else tied 0)

Behaviour:
- Reset: out_valid=0, in_ready=1, skid empty; all data outputs 0.
- Latency 1 cycle: accepted at edge N, visible on out_* after edge N when the main register is free.
- Main register + skid register. in_ready = !skid_valid (registered, no combinational path from out_ready).
- Accept with main full and out_ready=0: word goes to skid; in_ready drops next cycle.
- On consume: skid moves to main. Skid empty → main loads new accept, or empties if none.
- Simultaneous consume + accept with main full, skid empty: main takes the new entry, no bubble.
- Order strictly FIFO. Outputs stable while out_valid=1 and out_ready=0.
- flush: main and skid invalid next cycle; any same-cycle in_valid is dropped; flush has priority over accept and consume. Reset has priority over flush.
- Immediates:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All sign-extended from bit 31 to XLEN.
- Opcode → fmt:
  - LOAD, OP_IMM, JALR, SYSTEM, MISC_MEM → I
  - STORE → S
  - BRANCH → B
  - LUI, AUIPC → U
  - JAL → J
  - OP → R
- Illegal when any of:
  - instr[1:0] != 2'b11
  - unknown opcode
  - OP funct7 not 0000000, or 0100000 with funct3 other than 000/101
  - OP_IMM shift (funct3 001/101) with instr[31:25] not 0000000 (0100000 allowed for 101)
  - LOAD funct3 in {011, 110, 111}
  - STORE funct3 > 010
  - BRANCH funct3 in {010, 011}
  - JALR funct3 != 000
  - SYSTEM funct3 == 100
  - SYSTEM funct3 == 000 with imm12 not in {0, 1}
  - MISC_MEM funct3 > 001
- Illegal entries flow through the pipeline normally; no stall.

Optional Feature:
- QU_RV32M_EN defined: OP with funct7 0000001 is legal (all funct3), fmt R, out_is_mul=1.
- Undefined: that encoding is illegal; out_is_mul constant 0.

Decomposition:
- qu_pkg gains:
  - OP_IMM_OPCODE 7'b0010011 (load opcode kept separate)
  - STORE/LOAD/BRANCH aliases
  - FUNCT7_MULDIV 7'b0000001
  - instr_fmt_t enum (R..J)
  - decoded_instr_t packed struct holding all out_* fields
- Combinational field/immediate/legality logic in one sub-module, qu_decode_comb (instr in, decoded_instr_t out).
- qu_decoder holds the skid pipeline of decoded_instr_t.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), pc 0x100, out_ready=1 → next cycle: fmt 0, rd 3, rs1 1, rs2 2, imm 0, illegal 0, out_pc 0x100.
- ADDI x1,x0,-1 (0xFFF00093) → imm 0xFFFFFFFF, fmt 1. BEQ with offset -4 (0xFE000EE3) → imm 0xFFFFFFFC, fmt 3.
- Backpressure: 4 back-to-back words, out_ready=0 for 3 cycles → in_ready drops after 2 accepts, outputs stable. Release → all 4 emerge in order, no loss or duplication.
- Flush while main and skid full, with in_valid=1 the same cycle → out_valid=0 next cycle, the new word is dropped, in_ready=1.
- Word 0x00000000 → illegal 1. SRAI with funct7 0100000 (0x4010D093) → legal. SLLI with funct7 0100000 (0x40109093) → illegal.
- 0x022081B3 (MUL): with QU_RV32M_EN → illegal 0, out_is_mul 1. Without the macro → illegal 1, out_is_mul 0.

Source files
------------

// File: rtl/qu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qu_pkg
// Description : Shared RV32I decode constants, format enum and the decoded
//               instruction record carried through the decode pipeline.
//               Optional feature macro: QU_RV32M_EN (M-extension decode).
// Revision    : 1.0 - initial release
// ============================================================================
package qu_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] LOAD_OPCODE     = 7'b0000011;
    localparam logic [6:0] MISC_MEM_OPCODE = 7'b0001111;
    localparam logic [6:0] OP_IMM_OPCODE   = 7'b0010011;
    localparam logic [6:0] AUIPC_OPCODE    = 7'b0010111;
    localparam logic [6:0] STORE_OPCODE    = 7'b0100011;
    localparam logic [6:0] OP_OPCODE       = 7'b0110011;
    localparam logic [6:0] LUI_OPCODE      = 7'b0110111;
    localparam logic [6:0] BRANCH_OPCODE   = 7'b1100011;
    localparam logic [6:0] JALR_OPCODE     = 7'b1100111;
    localparam logic [6:0] JAL_OPCODE      = 7'b1101111;
    localparam logic [6:0] SYSTEM_OPCODE   = 7'b1110011;

    // Short aliases for the memory and branch opcodes
    localparam logic [6:0] OPC_LOAD   = LOAD_OPCODE;
    localparam logic [6:0] OPC_STORE  = STORE_OPCODE;
    localparam logic [6:0] OPC_BRANCH = BRANCH_OPCODE;

    // funct7 values
    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;

    // Immediate is kept at 32 bits here; the top sign-extends it to XLEN.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        instr_fmt_t  fmt;
        logic        illegal;
        logic        is_mul;
    } decoded_instr_t;

endpackage
`default_nettype wire

// File: rtl/qu_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : qu_decode_comb
// Description : Combinational RV32I field split, immediate generation,
//               format classification and illegal-encoding detection.
//               Optional feature macro: QU_RV32M_EN (funct7 0000001 on OP
//               decodes as a legal M-extension op).
// Revision    : 1.0 - initial release
// ============================================================================
module qu_decode_comb
    import qu_pkg::*;
(
    input  logic [31:0]    i_instr,
    output decoded_instr_t o_dec
);

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;

    assign w_f3    = i_instr[14:12];
    assign w_f7    = i_instr[31:25];
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Field split plus per-opcode format, immediate and legality
    always_comb begin
        o_dec         = '0;
        o_dec.opcode  = i_instr[6:0];
        o_dec.funct3  = w_f3;
        o_dec.funct7  = w_f7;
        o_dec.rd      = i_instr[11:7];
        o_dec.rs1     = i_instr[19:15];
        o_dec.rs2     = i_instr[24:20];
        o_dec.imm     = '0;
        o_dec.fmt     = FMT_R;
        o_dec.illegal = 1'b0;
        o_dec.is_mul  = 1'b0;

        case (i_instr[6:0])
            OPC_LOAD: begin
                o_dec.fmt     = FMT_I;
                o_dec.imm     = w_imm_i;
                o_dec.illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            MISC_MEM_OPCODE: begin
                o_dec.fmt     = FMT_I;
                o_dec.imm     = w_imm_i;
                o_dec.illegal = (w_f3 > 3'b001);
            end
            OP_IMM_OPCODE: begin
                o_dec.fmt = FMT_I;
                o_dec.imm = w_imm_i;
                // Shift-immediates reuse the upper imm bits as funct7
                if (w_f3 == 3'b001) begin
                    o_dec.illegal = (w_f7 != FUNCT7_BASE);
                end else if (w_f3 == 3'b101) begin
                    o_dec.illegal = (w_f7 != FUNCT7_BASE) && (w_f7 != FUNCT7_ALT);
                end
            end
            JALR_OPCODE: begin
                o_dec.fmt     = FMT_I;
                o_dec.imm     = w_imm_i;
                o_dec.illegal = (w_f3 != 3'b000);
            end
            SYSTEM_OPCODE: begin
                o_dec.fmt = FMT_I;
                o_dec.imm = w_imm_i;
                // funct3 000 only encodes ECALL (0) and EBREAK (1)
                if (w_f3 == 3'b100) begin
                    o_dec.illegal = 1'b1;
                end else if (w_f3 == 3'b000) begin
                    o_dec.illegal = (i_instr[31:20] > 12'd1);
                end
            end
            OPC_STORE: begin
                o_dec.fmt     = FMT_S;
                o_dec.imm     = w_imm_s;
                o_dec.illegal = (w_f3 > 3'b010);
            end
            OPC_BRANCH: begin
                o_dec.fmt     = FMT_B;
                o_dec.imm     = w_imm_b;
                o_dec.illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            LUI_OPCODE, AUIPC_OPCODE: begin
                o_dec.fmt = FMT_U;
                o_dec.imm = w_imm_u;
            end
            JAL_OPCODE: begin
                o_dec.fmt = FMT_J;
                o_dec.imm = w_imm_j;
            end
            OP_OPCODE: begin
                o_dec.fmt = FMT_R;
                if (w_f7 == FUNCT7_BASE) begin
                    o_dec.illegal = 1'b0;
                end else if ((w_f7 == FUNCT7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) begin
                    o_dec.illegal = 1'b0;
`ifdef QU_RV32M_EN
                end else if (w_f7 == FUNCT7_MULDIV) begin
                    o_dec.is_mul  = 1'b1;
`endif
                end else begin
                    o_dec.illegal = 1'b1;
                end
            end
            default: begin
                o_dec.illegal = 1'b1;
            end
        endcase

        // Compressed / non-32-bit encodings are never accepted
        if (i_instr[1:0] != 2'b11) begin
            o_dec.illegal = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : qu_decoder
// Description : Registered RV32I decode stage with valid/ready handshakes,
//               a main output register plus one skid register, and a
//               synchronous flush for branch redirect.
//               Optional feature macro: QU_RV32M_EN (M-extension decode).
// Revision    : 1.0 - initial release
// ============================================================================
module qu_decoder
    import qu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic [6:0]            out_funct7,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [XLEN-1:0]       out_imm,
    output logic [2:0]            out_fmt,
    output logic                  out_illegal,
    output logic                  out_is_mul
);

    decoded_instr_t        w_dec;
    logic                  w_accept;
    logic                  w_consume;

    logic                  r_main_valid;
    decoded_instr_t        r_main_dec;
    logic [ADDR_WIDTH-1:0] r_main_pc;
    logic                  r_skid_valid;
    decoded_instr_t        r_skid_dec;
    logic [ADDR_WIDTH-1:0] r_skid_pc;

    qu_decode_comb u_decode_comb (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready
    assign in_ready  = !r_skid_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_main_valid && out_ready;

    // Main/skid pipeline: flush beats consume/accept, skid refills main first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_dec   <= '0;
            r_main_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_dec   <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_consume) begin
            if (r_skid_valid) begin
                r_main_dec   <= r_skid_dec;
                r_main_pc    <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_dec   <= w_dec;
                r_main_pc    <= in_pc;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main_valid <= 1'b1;
                r_main_dec   <= w_dec;
                r_main_pc    <= in_pc;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_dec   <= w_dec;
                r_skid_pc    <= in_pc;
            end
        end
    end

    assign out_valid   = r_main_valid;
    assign out_pc      = r_main_pc;
    assign out_opcode  = r_main_dec.opcode;
    assign out_funct3  = r_main_dec.funct3;
    assign out_funct7  = r_main_dec.funct7;
    assign out_rd      = r_main_dec.rd;
    assign out_rs1     = r_main_dec.rs1;
    assign out_rs2     = r_main_dec.rs2;
    assign out_fmt     = r_main_dec.fmt;
    assign out_illegal = r_main_dec.illegal;
    assign out_is_mul  = r_main_dec.is_mul;

    generate
        if (XLEN > 32) begin : g_imm_ext
            assign out_imm = {{(XLEN-32){r_main_dec.imm[31]}}, r_main_dec.imm};
        end else begin : g_imm_direct
            assign out_imm = r_main_dec.imm;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_qu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_qu_decoder
// Description : Directed self-checking bench for qu_decoder: field/immediate
//               decode, legality, skid backpressure ordering and flush.
//               Optional feature macro: QU_RV32M_EN (changes MUL expectation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qu_decoder;

    localparam int XLEN       = 32;
    localparam int ADDR_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [6:0]            out_opcode;
    logic [2:0]            out_funct3;
    logic [6:0]            out_funct7;
    logic [4:0]            out_rd;
    logic [4:0]            out_rs1;
    logic [4:0]            out_rs2;
    logic [XLEN-1:0]       out_imm;
    logic [2:0]            out_fmt;
    logic                  out_illegal;
    logic                  out_is_mul;

    int n_checks = 0;
    int n_errors = 0;

    qu_decoder #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_is_mul  (out_is_mul)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single edge with out_ready held by caller
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    // Send a word and check validity, immediate, format and legality
    task automatic send_chk(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        send(instr, pc);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_pc"}, out_pc, pc);
        if (!ill) begin
            check({tag, "_imm"}, out_imm, imm);
            check({tag, "_fmt"}, out_fmt, fmt);
        end
        check({tag, "_illegal"}, out_illegal, ill);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_imm", out_imm, 32'h0);
        check("rst_out_opcode", out_opcode, 7'h0);
        rst = 1'b0;
        step();
        check("idle_out_valid", out_valid, 1'b0);

        // ADD x3,x1,x2
        send_chk("add", 32'h002081B3, 32'h100, 32'h0, 3'd0, 1'b0);
        check("add_rd", out_rd, 5'd3);
        check("add_rs1", out_rs1, 5'd1);
        check("add_rs2", out_rs2, 5'd2);
        check("add_opcode", out_opcode, 7'h33);
        check("add_is_mul", out_is_mul, 1'b0);

        send_chk("addi", 32'hFFF00093, 32'h104, 32'hFFFFFFFF, 3'd1, 1'b0);
        check("addi_rd", out_rd, 5'd1);
        send_chk("beq", 32'hFE000EE3, 32'h108, 32'hFFFFFFFC, 3'd3, 1'b0);
        check("beq_funct3", out_funct3, 3'd0);
        send_chk("sw", 32'h0020A423, 32'h10C, 32'h00000008, 3'd2, 1'b0);
        send_chk("lui", 32'h123452B7, 32'h110, 32'h12345000, 3'd4, 1'b0);
        check("lui_rd", out_rd, 5'd5);
        send_chk("jal", 32'hFF9FF0EF, 32'h114, 32'hFFFFFFF8, 3'd5, 1'b0);
        send_chk("srai", 32'h4010D093, 32'h118, 32'h00000401, 3'd1, 1'b0);
        check("srai_funct7", out_funct7, 7'h20);
        send_chk("zero", 32'h00000000, 32'h11C, 32'h0, 3'd0, 1'b1);
        send_chk("slli_alt", 32'h40109093, 32'h120, 32'h0, 3'd0, 1'b1);
        send_chk("ld_f3_011", 32'h00003003, 32'h124, 32'h0, 3'd0, 1'b1);
        send_chk("not_32bit", 32'h002081B0, 32'h128, 32'h0, 3'd0, 1'b1);
        send_chk("ecall", 32'h00000073, 32'h12C, 32'h0, 3'd1, 1'b0);
        send_chk("sys_imm2", 32'h00200073, 32'h130, 32'h0, 3'd0, 1'b1);
        send_chk("sub", 32'h402081B3, 32'h134, 32'h0, 3'd0, 1'b0);
        send_chk("and_alt", 32'h4020F1B3, 32'h138, 32'h0, 3'd0, 1'b1);

        // MUL x3,x1,x2
        send(32'h022081B3, 32'h13C);
        check("mul_valid", out_valid, 1'b1);
`ifdef QU_RV32M_EN
        check("mul_illegal", out_illegal, 1'b0);
        check("mul_is_mul", out_is_mul, 1'b1);
        check("mul_fmt", out_fmt, 3'd0);
`else
        check("mul_illegal", out_illegal, 1'b1);
        check("mul_is_mul", out_is_mul, 1'b0);
`endif
        step();
        check("drain_valid", out_valid, 1'b0);

        // Backpressure: main then skid fill, in_ready drops, outputs hold
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093; in_pc = 32'h200;
        step();
        check("bp_main_pc", out_pc, 32'h200);
        check("bp_ready_1", in_ready, 1'b1);
        in_instr  = 32'h00200093; in_pc = 32'h204;
        step();
        check("bp_ready_drop", in_ready, 1'b0);
        check("bp_hold_pc_a", out_pc, 32'h200);
        in_instr  = 32'h00300093; in_pc = 32'h208;
        step();
        check("bp_ready_low", in_ready, 1'b0);
        check("bp_hold_pc_b", out_pc, 32'h200);
        check("bp_hold_imm", out_imm, 32'h1);
        out_ready = 1'b1;
        step();
        check("bp_out1_pc", out_pc, 32'h204);
        check("bp_out1_imm", out_imm, 32'h2);
        check("bp_ready_back", in_ready, 1'b1);
        step();
        check("bp_out2_pc", out_pc, 32'h208);
        check("bp_out2_valid", out_valid, 1'b1);
        in_instr  = 32'h00400093; in_pc = 32'h20C;
        step();
        check("bp_out3_pc", out_pc, 32'h20C);
        check("bp_out3_imm", out_imm, 32'h4);
        in_valid  = 1'b0;
        step();
        check("bp_empty", out_valid, 1'b0);

        // Flush with main and skid full and a word offered the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093; in_pc = 32'h300;
        step();
        in_instr  = 32'h00600093; in_pc = 32'h304;
        step();
        check("fl_skid_full", in_ready, 1'b0);
        flush     = 1'b1;
        in_instr  = 32'h00700093; in_pc = 32'h308;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        step();
        check("fl_stays_empty", out_valid, 1'b0);

        // Flush beats a same-cycle accept while in_ready is high
        in_valid  = 1'b1;
        in_instr  = 32'h00800093; in_pc = 32'h310;
        step();
        check("fl2_main_pc", out_pc, 32'h310);
        flush     = 1'b1;
        in_instr  = 32'h00900093; in_pc = 32'h314;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("fl2_out_valid", out_valid, 1'b0);
        step();
        check("fl2_dropped", out_valid, 1'b0);

        // Normal flow resumes after flush
        out_ready = 1'b1;
        send_chk("post_fl", 32'h00A00093, 32'h318, 32'h0000000A, 3'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
